// File: rtl/keypad_matrix_emulator.sv
// 4x4 matrix-keypad model: accepts press commands and answers an active-low
// row scan on active-low column lines, with LFSR-driven contact bounce.
`timescale 1ns/1ps
module keypad_matrix_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 24000,
  parameter int unsigned TOGGLE_CYCLES = 240,
  parameter int unsigned HOLD_W        = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              bounce_en,
  input  logic [3:0]        rows,
  output logic [3:0]        columns,
  output logic              contact,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BCW = $clog2(BOUNCE_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TOGGLE_CYCLES + 1);

  localparam logic [BCW-1:0]    B_ONE  = BCW'(1);
  localparam logic [BCW-1:0]    B_LAST = BCW'(BOUNCE_CYCLES);
  localparam logic [TCW-1:0]    T_ONE  = TCW'(1);
  localparam logic [TCW-1:0]    T_LAST = TCW'(TOGGLE_CYCLES);
  localparam logic [HOLD_W-1:0] H_ONE  = HOLD_W'(1);
  localparam logic [15:0]       LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              contact_q, contact_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       lfsr_next;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [TCW-1:0]    tcnt_q, tcnt_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        key_q, key_d;
  logic              ben_q, ben_d;
  logic [3:0]        col_q, col_d;

  // Fibonacci taps x^16+x^14+x^13+x^11, shifted left with feedback into bit 0
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      contact_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      bcnt_q    <= '0;
      tcnt_q    <= '0;
      hcnt_q    <= '0;
      hold_q    <= '0;
      key_q     <= '0;
      ben_q     <= 1'b0;
      col_q     <= '1;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      contact_q <= contact_d;
      lfsr_q    <= lfsr_d;
      bcnt_q    <= bcnt_d;
      tcnt_q    <= tcnt_d;
      hcnt_q    <= hcnt_d;
      hold_q    <= hold_d;
      key_q     <= key_d;
      ben_q     <= ben_d;
      col_q     <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    contact_d = contact_q;
    lfsr_d    = lfsr_q;
    bcnt_d    = bcnt_q;
    tcnt_d    = tcnt_q;
    hcnt_d    = hcnt_q;
    hold_d    = hold_q;
    key_d     = key_q;
    ben_d     = ben_q;

    unique case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        if (cmd_valid && ready_q) begin
          key_d  = cmd_key;
          hold_d = (cmd_hold == '0) ? H_ONE : cmd_hold;
          ben_d  = bounce_en;
          if (bounce_en) begin
            state_d   = BOUNCE_IN;
            contact_d = lfsr_q[0];
            bcnt_d    = B_ONE;
            tcnt_d    = T_ONE;
          end else begin
            state_d   = HOLD;
            contact_d = 1'b1;
            hcnt_d    = H_ONE;
          end
        end
      end

      BOUNCE_IN, BOUNCE_OUT: begin
        // Phase end takes priority over a coinciding toggle tick
        if (bcnt_q >= B_LAST) begin
          if (state_q == BOUNCE_IN) begin
            state_d   = HOLD;
            contact_d = 1'b1;
            hcnt_d    = H_ONE;
          end else begin
            state_d   = DONE;
            contact_d = 1'b0;
          end
        end else begin
          bcnt_d = bcnt_q + B_ONE;
          if (tcnt_q >= T_LAST) begin
            lfsr_d    = lfsr_next;
            contact_d = lfsr_next[0];
            tcnt_d    = T_ONE;
          end else begin
            tcnt_d = tcnt_q + T_ONE;
          end
        end
      end

      HOLD: begin
        if (hcnt_q >= hold_q) begin
          if (ben_q) begin
            state_d   = BOUNCE_OUT;
            contact_d = lfsr_q[0];
            bcnt_d    = B_ONE;
            tcnt_d    = T_ONE;
          end else begin
            state_d   = DONE;
            contact_d = 1'b0;
          end
        end else begin
          hcnt_d = hcnt_q + H_ONE;
        end
      end

      DONE: begin
        state_d   = IDLE;
        contact_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);

    col_d = '1;
    for (int unsigned c = 0; c < 4; c++) begin
      col_d[c] = ~(contact_q && (key_q[1:0] == c[1:0]) && !rows[key_q[3:2]]);
    end
  end

  assign cmd_ready = ready_q;
  assign columns   = col_q;
  assign contact   = contact_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator with a reference LFSR/contact model.
`timescale 1ns/1ps
module tb_keypad_matrix_emulator;

  localparam int unsigned BC     = 32;
  localparam int unsigned TC     = 4;
  localparam int unsigned HOLD_W = 24;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;
  logic              bounce_en;
  logic [3:0]        rows;
  logic [3:0]        columns;
  logic              contact;
  logic              busy;
  logic              done;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [15:0] lfsr_ref;

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES(BC),
    .TOGGLE_CYCLES(TC),
    .HOLD_W       (HOLD_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_key  (cmd_key),
    .cmd_hold (cmd_hold),
    .bounce_en(bounce_en),
    .rows     (rows),
    .columns  (columns),
    .contact  (contact),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] l, input int unsigned n);
    logic [15:0] v;
    v = l;
    for (int unsigned i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  // Packs {ready, busy, done, contact, columns} for one-shot comparison
  function automatic logic [7:0] obs_vec();
    return {cmd_ready, busy, done, contact, columns};
  endfunction

  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (!cmd_ready && n < 400) begin
      step();
      n++;
    end
    chk({tag, " ready"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  // Issues one press with fixed rows and checks every cycle up to the return to idle
  task automatic run_press(input logic [3:0] key, input logic [HOLD_W-1:0] hold,
                           input logic ben, input logic [3:0] rw, input string tag);
    int unsigned h, total, hs, os;
    logic [15:0] lf, t;
    logic        exp_c, prev_c;
    logic [3:0]  ec;
    h     = (hold == '0) ? 1 : int'(hold);
    hs    = ben ? BC : 0;
    os    = hs + h;
    total = ben ? (2 * BC + h + 1) : (h + 1);
    wait_ready(tag);
    rows      = rw;
    cmd_key   = key;
    cmd_hold  = hold;
    bounce_en = ben;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    lf     = lfsr_ref;
    prev_c = 1'b0;
    for (int unsigned k = 0; k <= total; k++) begin
      exp_c = 1'b0;
      if (ben && k < BC) begin
        t     = adv(lf, k / TC);
        exp_c = t[0];
      end else if (k >= hs && k < os) begin
        exp_c = 1'b1;
      end else if (ben && k >= os && k < os + BC) begin
        t     = adv(lf, (BC - 1) / TC + (k - os) / TC);
        exp_c = t[0];
      end
      ec = 4'b1111;
      if (prev_c && !rw[key[3:2]]) ec[key[1:0]] = 1'b0;
      chk($sformatf("%s k=%0d", tag, k), {24'b0, obs_vec()},
          {24'b0, (k == total), (k < total), (k == total - 1), exp_c, ec});
      prev_c = exp_c;
      if (k < total) step();
    end
    if (ben) lfsr_ref = adv(lf, 2 * ((BC - 1) / TC));
  endtask

  initial begin
    logic [3:0] rp [4];
    logic [3:0] ec;
    logic [3:0] rows_at_edge;
    logic       prev_c, exp_c;
    logic [7:0] ev;

    rp[0] = 4'b1110; rp[1] = 4'b1101; rp[2] = 4'b1011; rp[3] = 4'b0111;
    lfsr_ref  = 16'hACE1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    cmd_hold  = '0;
    bounce_en = 1'b0;
    rows      = 4'b1111;

    // Power-on reset
    step();
    step();
    chk("reset state", {24'b0, obs_vec()}, {24'b0, 8'b0000_1111});
    reset = 1'b0;
    step();
    chk("ready after reset", {31'b0, cmd_ready}, 32'd1);

    // Plain press, no bounce
    run_press(4'h6, 24'd10, 1'b0, 4'b1101, "nobounce");

    // Row selectivity with a rotating scan
    wait_ready("rowsel");
    cmd_key   = 4'h6;
    cmd_hold  = 24'd10;
    bounce_en = 1'b0;
    rows      = rp[0];
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    prev_c = 1'b0;
    for (int unsigned k = 0; k <= 11; k++) begin
      rows_at_edge = rp[k % 4];
      exp_c = (k < 10);
      ec = 4'b1111;
      if (prev_c && !rows_at_edge[1]) ec[2] = 1'b0;
      chk($sformatf("rowsel k=%0d", k), {27'b0, contact, columns}, {27'b0, exp_c, ec});
      prev_c = exp_c;
      rows = rp[(k + 1) % 4];
      if (k < 11) step();
    end

    // hold=0 behaves as 1; all rows low still selects only the key column
    run_press(4'h6, 24'd0, 1'b0, 4'b0000, "hold0");

    // Backpressure: command offered during HOLD is dropped, then taken in first IDLE cycle
    wait_ready("bp");
    cmd_key   = 4'h6;
    cmd_hold  = 24'd10;
    bounce_en = 1'b0;
    rows      = 4'b1101;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int unsigned k = 0; k <= 15; k++) begin
      if (k == 0)       ev = 8'b0101_1111;
      else if (k <= 9)  ev = 8'b0101_1011;
      else if (k == 10) ev = 8'b0110_1011;
      else if (k == 11) ev = 8'b1000_1111;
      else if (k == 12) ev = 8'b0101_1111;
      else if (k == 13) ev = 8'b0101_1110;
      else if (k == 14) ev = 8'b0110_1110;
      else              ev = 8'b1000_1111;
      chk($sformatf("bp k=%0d", k), {24'b0, obs_vec()}, {24'b0, ev});
      if (k == 2) begin
        cmd_key   = 4'h0;
        cmd_hold  = 24'd2;
        cmd_valid = 1'b1;
      end
      if (k == 11) rows = 4'b1110;
      if (k == 12) cmd_valid = 1'b0;
      if (k < 15) step();
    end

    // Bounced press on the corner key
    run_press(4'hF, 24'd100, 1'b1, 4'b0111, "bounce");

    // Reset in the middle of HOLD
    run_press_start: begin
      wait_ready("midreset");
      cmd_key   = 4'h6;
      cmd_hold  = 24'd50;
      bounce_en = 1'b0;
      rows      = 4'b1101;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int unsigned i = 0; i < 6; i++) step();
      chk("midreset in hold", {30'b0, busy, contact}, 32'd3);
      reset = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        step();
        chk($sformatf("midreset r%0d", i), {24'b0, obs_vec()}, {24'b0, 8'b0000_1111});
      end
      reset = 1'b0;
      step();
      chk("midreset release", {24'b0, obs_vec()}, {24'b0, 8'b1000_1111});
    end

    // LFSR must restart from its seed after reset
    lfsr_ref = 16'hACE1;
    run_press(4'hF, 24'd3, 1'b1, 4'b0111, "postreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable 4x4 matrix-keypad model that answers the row-scanning keypad reader.
- Accepts key-press commands, then drives active-low column lines in response to the reader's active-low row drive, including deterministic contact bounce on press and release.
- Used in a second FPGA or in simulation as a hardware-in-loop stimulus for the scanner/debouncer path, clocked from the 24 MHz HSOSC domain.

Parameters:
- BOUNCE_CYCLES, 24000, length in clk cycles of each bounce phase (1 ms at 24 MHz).
- TOGGLE_CYCLES, 240, clk cycles between contact-state updates during bounce (10 us).
- HOLD_W, 24, width of the stable-hold cycle count.

Ports:
- clk  in  1  system clock (HSOSC).
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  emulator idle; command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_key  in  4  key index; row = cmd_key[3:2], col = cmd_key[1:0].
- cmd_hold  in  HOLD_W  stable-closed duration in cycles; 0 is treated as 1.
- bounce_en  in  1  sampled with the command; 0 skips both bounce phases.
- rows  in  4  active-low row drive from the scanner.
- columns  out  4  active-low column sense to the scanner; idle 4'b1111.
- contact  out  1  current modelled switch state (1 = closed).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (synchronous, edge where reset=1): state IDLE; cmd_ready=0 during the reset cycle, then 1; columns=4'b1111; contact=0; busy=0; done=0; all counters 0; LFSR=16'hACE1. Reset overrides any state, including mid-bounce and mid-hold.
- Column path is registered, with one-cycle latency from rows/contact: columns[c] <= ~(contact & (c==key_col) & ~rows[key_row]). All other column bits are 1. Multiple rows low is legal; only the latched key row matters.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, DONE.
- IDLE: cmd_ready=1. On accept, latch key, hold (0->1) and bounce_en. Go to BOUNCE_IN if bounce_en, else HOLD.
- Bounce phases:
  - On entry, contact <= lfsr[0] and a counter runs for BOUNCE_CYCLES cycles.
  - Every TOGGLE_CYCLES cycles within the phase, the LFSR advances (x^16+x^14+x^13+x^11, Fibonacci, shift left, feedback into bit 0) and contact <= new lfsr[0].
  - The LFSR advances only on these ticks, so sequences are reproducible from reset.
- BOUNCE_IN ends -> HOLD.
- HOLD: contact=1 for exactly hold cycles, counted from the first HOLD cycle. Then -> BOUNCE_OUT if bounce_en, else DONE.
- BOUNCE_OUT ends -> DONE.
- DONE: contact=0, done=1 for one cycle, -> IDLE.
- cmd_valid while busy is ignored; no queuing and no error.
- Counters saturate: no wrap. HOLD_W-bit hold of all ones is legal.
- Press with bounce_en=0 and hold=H: contact high exactly H cycles, starting the cycle after accept. done asserts in the cycle after contact falls.

Test Plan:
- Reset: assert reset 3 cycles mid-HOLD -> next cycle columns=4'b1111, contact=0, busy=0, cmd_ready=1 one cycle after reset drops.
- No-bounce press: key=4'h6, hold=10, bounce_en=0, rows held 4'b1101 -> contact=1 for 10 cycles; columns=4'b1011 for 10 cycles lagging contact by one; done pulse once; busy back to 0.
- Row selectivity: same press with rows cycling 1110/1101/1011/0111 each cycle -> columns[2] low only the cycle after rows=1101 while contact=1; otherwise 4'b1111. rows=4'b0000 -> columns=4'b1011.
- Bounce: key=4'hF, hold=100, bounce_en=1, TOGGLE_CYCLES=4, BOUNCE_CYCLES=32 -> contact changes only on 4-cycle ticks, matching a reference LFSR from 16'hACE1; total busy = 32+100+32+1 cycles.
- Backpressure: offer a second command during HOLD -> cmd_ready=0, command dropped; a command offered in the first IDLE cycle is accepted.
- hold=0 -> contact high exactly 1 cycle; done follows.
